// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between the littlecpu fetch
// port and its data port. Data wins over fetch, except that a pending fetch
// is forced through after STARVE_LIMIT back-to-back data grants. A granted
// request is latched and held on the bus until memory answers. A dead slave
// is cut off after TIMEOUT bus cycles, and the owner gets a NOP instead.
// All outputs come straight from flops.

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_valid,
    output logic [31:0] d_rdata,

    output logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,

    output logic        timeout
);

    // The starvation counter is at least 3 bits wide and saturates at all-ones.
    localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [STARVE_W-1:0] STARVE_LIM_C = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX_C = {STARVE_W{1'b1}};
    localparam logic [STARVE_W-1:0] STARVE_ONE_C = STARVE_W'(1);

    // wait_cnt_r holds the number of BUSY cycles already completed. The
    // cycle in which it equals TIMEOUT-1 is the TIMEOUT-th bus cycle. If
    // memory is still silent then, the transaction is aborted. This makes
    // mem_ready stay high for exactly TIMEOUT cycles on a dead slave.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST_C = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE_C  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO_C = {WAIT_W{1'b0}};
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);

    // A fetch that dies on the bus is answered with this RISC-V NOP (addi x0,x0,0).
    localparam logic [31:0] NOP_C = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY_I = 2'b01,
        ST_BUSY_D = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                grant_i_s;
    logic                grant_d_s;
    logic                done_s;
    logic                abort_s;

    logic [STARVE_W-1:0] starve_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;

    logic                mem_ready_r;
    logic [31:0]         mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic [3:0]          mem_wstrb_r;
    logic                i_valid_r;
    logic [31:0]         i_rdata_r;
    logic                d_valid_r;
    logic [31:0]         d_rdata_r;
    logic                timeout_r;

    // Next-state logic: grant decision in IDLE, and completion or abort in BUSY.
    always_comb begin
        state_s   = state_r;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Data has priority unless the fetch side has waited through
                // STARVE_LIMIT data grants in a row.
                if (d_req && ((starve_cnt_r < STARVE_LIM_C) || !i_req)) begin
                    state_s   = ST_BUSY_D;
                    grant_d_s = 1'b1;
                end else if (i_req) begin
                    state_s   = ST_BUSY_I;
                    grant_i_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // A real response beats a timeout that lands in the same cycle.
                if (mem_valid) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (TIMEOUT_EN && (wait_cnt_r == WAIT_LAST_C)) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bus side: latch the winner's request at grant time and hold it until the transaction ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_ready_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'h0;
        end else begin
            mem_ready_r <= (state_s != ST_IDLE);
            if (grant_d_s) begin
                mem_addr_r  <= d_addr;
                mem_wdata_r <= d_wdata;
                mem_wstrb_r <= d_wstrb;
            end else if (grant_i_s) begin
                // A fetch is always a read, so strobes are forced to 0.
                mem_addr_r  <= i_addr;
                mem_wdata_r <= 32'h0000_0000;
                mem_wstrb_r <= 4'h0;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
                mem_wstrb_r <= mem_wstrb_r;
            end
        end
    end

    // Fetch response: one-cycle strobe with memory data, or a NOP after an abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_valid_r <= 1'b0;
            i_rdata_r <= 32'h0000_0000;
        end else begin
            i_valid_r <= (state_r == ST_BUSY_I) && (done_s || abort_s);
            if ((state_r == ST_BUSY_I) && done_s) begin
                i_rdata_r <= mem_rdata;
            end else if ((state_r == ST_BUSY_I) && abort_s) begin
                i_rdata_r <= NOP_C;
            end else begin
                i_rdata_r <= i_rdata_r;
            end
        end
    end

    // Data response: one-cycle strobe with memory data, or a NOP word after an abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid_r <= 1'b0;
            d_rdata_r <= 32'h0000_0000;
        end else begin
            d_valid_r <= (state_r == ST_BUSY_D) && (done_s || abort_s);
            if ((state_r == ST_BUSY_D) && done_s) begin
                d_rdata_r <= mem_rdata;
            end else if ((state_r == ST_BUSY_D) && abort_s) begin
                d_rdata_r <= NOP_C;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    // Abort indication: one-cycle pulse in the same cycle as the NOP response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= abort_s;
        end
    end

    // Bus-cycle counter: restarts at every grant and advances while a transaction is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= WAIT_ZERO_C;
        end else if (grant_i_s || grant_d_s) begin
            wait_cnt_r <= WAIT_ZERO_C;
        end else if (state_r != ST_IDLE) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE_C;
        end else begin
            wait_cnt_r <= WAIT_ZERO_C;
        end
    end

    // Starvation guard: counts data grants made while a fetch is waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (grant_d_s) begin
            if (i_req) begin
                if (starve_cnt_r != STARVE_MAX_C) begin
                    starve_cnt_r <= starve_cnt_r + STARVE_ONE_C;
                end else begin
                    starve_cnt_r <= starve_cnt_r;
                end
            end else begin
                starve_cnt_r <= {STARVE_W{1'b0}};
            end
        end else if (grant_i_s) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign mem_ready = mem_ready_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign i_valid   = i_valid_r;
    assign i_rdata   = i_rdata_r;
    assign d_valid   = d_valid_r;
    assign d_rdata   = d_rdata_r;
    assign timeout   = timeout_r;

endmodule
